// File: rtl/cos_pkg.sv
// Shared types and widths for the cos_job_controller slice.
package cos_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} cjc_state_t;

    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned INT_W  = 2;
    localparam int unsigned FRAC_W = 8;

endpackage

// File: rtl/cjc_timer.sv
// Loadable up-counter with terminal-count compare. tc is high while the count
// equals `last`, so a limit of N is reached on the N-th enabled cycle after a clear.
module cjc_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == last);

endmodule

// File: rtl/cos_job_controller.sv
// Initiator-side job controller for the coss cosine engine: accepts a request,
// pulses start for START_CYCLES cycles, waits for a done rising edge or a
// timeout, and returns the result on a valid/ready response port.
module cos_job_controller
    import cos_pkg::*;
#(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned CNT_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_x,
    input  logic [Y_W-1:0]    req_y,
    output logic              cos_start,
    output logic [X_W-1:0]    cos_x,
    output logic [Y_W-1:0]    cos_y,
    input  logic              cos_done,
    input  logic [INT_W-1:0]  cos_intpart,
    input  logic [FRAC_W-1:0] cos_fracpart,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [INT_W-1:0]  rsp_int,
    output logic [FRAC_W-1:0] rsp_frac,
    output logic              rsp_timeout,
    output logic              busy
);

    // The timer compares against count-1 so "last" is hit on the N-th cycle.
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    cjc_state_t        state_q, state_d;
    logic              cos_start_q, cos_start_d;
    logic [X_W-1:0]    cos_x_q, cos_x_d;
    logic [Y_W-1:0]    cos_y_q, cos_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [INT_W-1:0]  rsp_int_q, rsp_int_d;
    logic [FRAC_W-1:0] rsp_frac_q, rsp_frac_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              done_q;
    logic              done_rise;
    logic              timer_clr, timer_en, timer_tc;
    logic [CNT_W-1:0]  timer_last;

    // done_q tracks cos_done every cycle, so a done left high from an
    // earlier job never looks like a fresh edge once WAIT is entered.
    assign done_rise = cos_done & ~done_q;

    // One timer serves both the start-pulse length and the WAIT timeout.
    cjc_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (timer_last),
        .tc   (timer_tc)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        cos_start_d   = cos_start_q;
        cos_x_d       = cos_x_q;
        cos_y_d       = cos_y_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_int_d     = rsp_int_q;
        rsp_frac_d    = rsp_frac_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;
        timer_last    = START_LAST;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cos_x_d     = req_x;
                    cos_y_d     = req_y;
                    cos_start_d = 1'b1;
                    timer_clr   = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    cos_start_d = 1'b0;
                    timer_clr   = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                timer_last = TIMEOUT_LAST;
                timer_en   = 1'b1;
                // A done edge in the timeout cycle still returns real data.
                if (done_rise) begin
                    rsp_int_d     = cos_intpart;
                    rsp_frac_d    = cos_fracpart;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else if (timer_tc) begin
                    rsp_int_d     = '0;
                    rsp_frac_d    = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and done-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cos_start_q   <= 1'b0;
            cos_x_q       <= '0;
            cos_y_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_int_q     <= '0;
            rsp_frac_q    <= '0;
            rsp_timeout_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cos_start_q   <= cos_start_d;
            cos_x_q       <= cos_x_d;
            cos_y_q       <= cos_y_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_int_q     <= rsp_int_d;
            rsp_frac_q    <= rsp_frac_d;
            rsp_timeout_q <= rsp_timeout_d;
            done_q        <= cos_done;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign cos_start   = cos_start_q;
    assign cos_x       = cos_x_q;
    assign cos_y       = cos_y_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_int     = rsp_int_q;
    assign rsp_frac    = rsp_frac_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cos_job_controller.sv
// Bench for cos_job_controller: a timestamp-based job model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cos_job_controller;

    localparam int START = 2;
    localparam int TOUT  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_x;
    logic [7:0] req_y;
    logic       cos_start;
    logic [9:0] cos_x;
    logic [7:0] cos_y;
    logic       cos_done;
    logic [1:0] cos_intpart;
    logic [7:0] cos_fracpart;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_int;
    logic [7:0] rsp_frac;
    logic       rsp_timeout;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    cos_job_controller #(
        .START_CYCLES (START),
        .TIMEOUT      (TOUT),
        .CNT_W        (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .cos_start    (cos_start),
        .cos_x        (cos_x),
        .cos_y        (cos_y),
        .cos_done     (cos_done),
        .cos_intpart  (cos_intpart),
        .cos_fracpart (cos_fracpart),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_int      (rsp_int),
        .rsp_frac     (rsp_frac),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level model ----------------
    // A job is described by its accept cycle; launch, wait window and
    // deadline are derived from it arithmetically.
    int         cyc = 0;
    int         m_acc = 0;
    bit         m_busy, m_have_rsp, m_prev_done, m_to;
    logic [9:0] m_x;
    logic [7:0] m_y;
    logic [1:0] m_int;
    logic [7:0] m_frac;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_have_rsp  <= 1'b0;
            m_prev_done <= 1'b0;
            m_to        <= 1'b0;
            m_x         <= '0;
            m_y         <= '0;
            m_int       <= '0;
            m_frac      <= '0;
        end else begin
            cyc         <= cyc + 1;
            m_prev_done <= cos_done;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy     <= 1'b1;
                    m_have_rsp <= 1'b0;
                    m_acc      <= cyc;
                    m_x        <= req_x;
                    m_y        <= req_y;
                end
            end else if (!m_have_rsp) begin
                if (cyc >= m_acc + START + 1) begin
                    if (cos_done && !m_prev_done) begin
                        m_have_rsp <= 1'b1;
                        m_int      <= cos_intpart;
                        m_frac     <= cos_fracpart;
                        m_to       <= 1'b0;
                    end else if (cyc == m_acc + START + TOUT) begin
                        m_have_rsp <= 1'b1;
                        m_int      <= '0;
                        m_frac     <= '0;
                        m_to       <= 1'b1;
                    end
                end
            end else if (rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_start;
        exp_start = m_busy && !m_have_rsp && (cyc > m_acc) && (cyc <= m_acc + START);
        chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("cos_start", {31'b0, cos_start}, {31'b0, exp_start});
        chk("cos_x", {22'b0, cos_x}, {22'b0, m_x});
        chk("cos_y", {24'b0, cos_y}, {24'b0, m_y});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy && m_have_rsp});
        chk("rsp_int", {30'b0, rsp_int}, {30'b0, m_int});
        chk("rsp_frac", {24'b0, rsp_frac}, {24'b0, m_frac});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, m_to});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a request and step to the first WAIT cycle, checking the start pulse.
    task automatic start_job(input logic [9:0] x, input logic [7:0] y);
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("start_c1", {31'b0, cos_start}, 32'd1);
        chk("job_x", {22'b0, cos_x}, {22'b0, x});
        tick();
        chk("start_c2", {31'b0, cos_start}, 32'd1);
        tick();
        chk("start_off", {31'b0, cos_start}, 32'd0);
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hs_valid", {31'b0, rsp_valid}, 32'd0);
        chk("hs_idle", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_x        = '0;
        req_y        = '0;
        cos_done     = 1'b0;
        cos_intpart  = '0;
        cos_fracpart = '0;
        rsp_ready    = 1'b0;
        repeat (2) tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_start", {31'b0, cos_start}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic job: done 20 cycles after start falls.
        start_job(10'b0100001100, 8'h00);
        repeat (19) tick();
        cos_intpart  = 2'b00;
        cos_fracpart = 8'hD7;
        cos_done     = 1'b1;
        chk("basic_pre", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("basic_valid", {31'b0, rsp_valid}, 32'd1);
        chk("basic_int", {30'b0, rsp_int}, 32'd0);
        chk("basic_frac", {24'b0, rsp_frac}, 32'hD7);
        chk("basic_to", {31'b0, rsp_timeout}, 32'd0);
        cos_done = 1'b0;
        handshake();

        // Backpressure with an ignored second request.
        start_job(10'b0100001100, 8'h00);
        repeat (19) tick();
        cos_fracpart = 8'hD7;
        cos_done     = 1'b1;
        tick();
        cos_done     = 1'b0;
        cos_fracpart = 8'h99;
        req_x        = 10'h3FF;
        req_valid    = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("bp_frac", {24'b0, rsp_frac}, 32'hD7);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        handshake();
        chk("bp_x_kept", {22'b0, cos_x}, 32'h10C);

        // Stale done held through LAUNCH, low at W3, high again at W8.
        cos_fracpart = 8'h11;
        cos_done     = 1'b1;
        tick();
        start_job(10'h155, 8'hA5);
        tick();
        tick();
        cos_done = 1'b0;
        repeat (5) tick();
        cos_fracpart = 8'h40;
        cos_done     = 1'b1;
        chk("stale_none", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("stale_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stale_frac", {24'b0, rsp_frac}, 32'h40);
        handshake();
        repeat (3) tick();
        chk("stale_once", {31'b0, busy}, 32'd0);
        cos_done = 1'b0;
        tick();

        // Timeout: done never rises.
        cos_intpart  = 2'b11;
        cos_fracpart = 8'hFF;
        start_job(10'h0AA, 8'h3C);
        n = 1;
        while (!rsp_valid && n < 100) begin
            tick();
            if (!rsp_valid) n++;
        end
        chk("to_latency", n, TOUT);
        chk("to_flag", {31'b0, rsp_timeout}, 32'd1);
        chk("to_int", {30'b0, rsp_int}, 32'd0);
        chk("to_frac", {24'b0, rsp_frac}, 32'd0);
        handshake();

        // Done edge in the very cycle the timeout is reached.
        start_job(10'h001, 8'h02);
        repeat (TOUT - 1) tick();
        cos_intpart  = 2'b10;
        cos_fracpart = 8'h5A;
        cos_done     = 1'b1;
        tick();
        chk("col_valid", {31'b0, rsp_valid}, 32'd1);
        chk("col_to", {31'b0, rsp_timeout}, 32'd0);
        chk("col_int", {30'b0, rsp_int}, 32'd2);
        chk("col_frac", {24'b0, rsp_frac}, 32'h5A);
        cos_done = 1'b0;
        handshake();

        // Reset during LAUNCH: start must drop before any clock edge.
        req_x     = 10'h2F0;
        req_y     = 8'h77;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rl_start_hi", {31'b0, cos_start}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rl_start", {31'b0, cos_start}, 32'd0);
        chk("rl_busy", {31'b0, busy}, 32'd0);
        chk("rl_x", {22'b0, cos_x}, 32'd0);
        chk("rl_frac", {24'b0, rsp_frac}, 32'd0);
        tick();
        rst = 1'b0;
        chk("rl_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // Reset during WAIT.
        start_job(10'h123, 8'h45);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rw_busy", {31'b0, busy}, 32'd0);
        chk("rw_y", {24'b0, cos_y}, 32'd0);
        chk("rw_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        chk("rw_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // Normal job after reset.
        start_job(10'h321, 8'h54);
        repeat (9) tick();
        cos_intpart  = 2'b01;
        cos_fracpart = 8'h33;
        cos_done     = 1'b1;
        tick();
        chk("post_valid", {31'b0, rsp_valid}, 32'd1);
        chk("post_int", {30'b0, rsp_int}, 32'd1);
        chk("post_frac", {24'b0, rsp_frac}, 32'h33);
        cos_done = 1'b0;
        handshake();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
